uart_rx: RTL

- 8N1 UART receiver, the receive counterpart of the uart_fsm transmitter.
- Runs directly on the 12 MHz board clock; mid-bit sampling uses an internal bit-period counter, so it needs no external baud clock.
- Delivers each received byte on a valid/ack handshake to on-chip logic (e.g. echo-back or LED test logic in top).
- Line input is the FTDI TX-to-FPGA pin.

---
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver running directly on the board clock.
// The line is double-flopped, each bit is sampled at its middle using a
// bit-period counter, and every good byte is offered on a valid/ack handshake.
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ftdi_rx,
    input  logic                  rx_en,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ack,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Half a bit period (rounded down) moves sampling from the falling start
    // edge to the middle of the start bit; later samples are a full period apart.
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchronizer
    logic sync1_q, sync2_q;
    logic rx_s;

    // Framing FSM
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    good_q, good_d;
    logic                    ferr_q, ferr_d;

    // Delivery / handshake
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;

    // Two-flop synchronizer; preset high so reset looks like an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ftdi_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Frame FSM next state: start qualification, data shift, stop check, break wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        good_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_en && !rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF) begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Leave at mid-stop so a start bit right after is caught.
                        good_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_BREAK: begin
                // A line held low must go high before a new start is accepted.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame FSM registers plus the one-cycle good/frame-error strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            good_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            good_q  <= good_d;
            ferr_q  <= ferr_d;
        end
    end

    // Handshake next state: load a good byte if the slot is free or being
    // acked this cycle, otherwise drop it and flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;

        if (good_q) begin
            if (!valid_q || ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
    end

    // Handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
